uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_tick.sv | 30 +++
 rtl/uart_rx_ext.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the extended UART receiver: parity modes, FSM state
// encodings and the 2-of-3 bit vote used when deciding a bit value.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_PUSH   = 3'd5
  } rx_state_e;

  // Majority of three samples: two already-accumulated votes plus the current one.
  function automatic logic maj3(input logic [1:0] votes, input logic s);
    logic [1:0] sum;
    sum = votes + {1'b0, s};
    return (sum >= 2'd2);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks while enabled;
// the divider restarts from zero whenever the enable is low.
module uart_rx_tick #(
  parameter int DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  // Count clocks while enabled and pulse tick when a full divide period elapses.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= {CW{1'b0}};
      tick  <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= {CW{1'b0}};
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with 3-sample majority voting, optional parity,
// 1 or 2 checked stop bits and a first-word-fall-through receive FIFO that
// stores per-word frame/parity error flags.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = DATA_BITS + 2;

  // Sample points straddle the bit centre; the last one is where the bit is decided.
  localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S2   = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e            state_q;
  logic [PW-1:0]        phase_q, phase_d;
  logic [1:0]           vote_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 ferr_q, perr_q;
  logic                 tick_s, fall_s, decide_s, wrap_s, bit_s, en_s;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 overrun_q;
  logic                 push_s, full_s, wr_s, pop_s;
  logic [EW-1:0]        head_s;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en_s),
    .tick (tick_s)
  );

  // Two-flop synchronizer plus one history flop for falling-edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Tick phase bookkeeping and per-bit strobes derived from it.
  always_comb begin
    en_s   = (state_q != ST_IDLE);
    fall_s = rx_prev_q & ~rx_sync_q;
    if (phase_q == PH_LAST) begin
      phase_d = {PW{1'b0}};
    end else begin
      phase_d = phase_q + 1'b1;
    end
    decide_s = tick_s && (phase_d == PH_S2);
    wrap_s   = tick_s && (phase_q == PH_LAST);
    bit_s    = maj3(vote_q, rx_sync_q);
  end

  // Receive FSM: bit sampling, shifting, parity and stop checks, one-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= {PW{1'b0}};
      vote_q     <= 2'd0;
      bit_cnt_q  <= {BW{1'b0}};
      stop_cnt_q <= 1'b0;
      shreg_q    <= {DATA_BITS{1'b0}};
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      if (tick_s && en_s) begin
        phase_q <= phase_d;
        if (phase_d == PH_S0) begin
          vote_q <= {1'b0, rx_sync_q};
        end else if (phase_d == PH_S1) begin
          vote_q <= vote_q + {1'b0, rx_sync_q};
        end else begin
          vote_q <= vote_q;
        end
      end
      case (state_q)
        ST_IDLE: begin
          phase_q    <= {PW{1'b0}};
          vote_q     <= 2'd0;
          bit_cnt_q  <= {BW{1'b0}};
          stop_cnt_q <= 1'b0;
          ferr_q     <= 1'b0;
          perr_q     <= 1'b0;
          if (fall_s) state_q <= ST_START;
        end
        ST_START: begin
          if (decide_s && bit_s) state_q <= ST_IDLE;
          else if (wrap_s)       state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (decide_s) begin
            shreg_q   <= {bit_s, shreg_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          if (wrap_s && (bit_cnt_q == BW'(DATA_BITS))) begin
            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (decide_s) begin
            perr_q <= (PARITY == PAR_ODD) ? ~(^{shreg_q, bit_s}) : (^{shreg_q, bit_s});
          end
          if (wrap_s) state_q <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at the decision point so a start bit right after the stop bit is caught.
          if (decide_s) begin
            if (!bit_s) ferr_q <= 1'b1;
            if (stop_cnt_q == 1'(STOP_BITS - 1)) state_q <= ST_PUSH;
            else                                 stop_cnt_q <= 1'b1;
          end
        end
        ST_PUSH: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign push_s = (state_q == ST_PUSH);
  assign full_s = (count_q == CW'(FIFO_DEPTH));
  assign wr_s   = push_s & ~full_s;
  assign pop_s  = valid & ready;

  // Receive FIFO: write on PUSH when not full, pop on valid&ready, pulse overrun on drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {EW{1'b0}};
    end else begin
      overrun_q <= push_s & full_s;
      if (wr_s) begin
        mem_q[wr_ptr_q] <= {perr_q, ferr_q, shreg_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_s     = mem_q[rd_ptr_q];
  assign data       = head_s[DATA_BITS-1:0];
  assign frame_err  = head_s[DATA_BITS];
  assign parity_err = head_s[DATA_BITS+1];
  assign valid      = (count_q != {CW{1'b0}});
  assign overrun    = overrun_q;
  assign busy       = en_s;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: one default instance and one even-parity instance.
module tb_uart_rx_ext;

  localparam int BIT = 104;  // 13 clocks per tick * 8 ticks per bit at defaults

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
  logic valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_a = 0;
  int busy_seen = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  always #5 clk = ~clk;

  uart_rx_ext dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_ext #(.PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b),
    .frame_err(frame_err_b), .parity_err(parity_err_b), .overrun(overrun_b), .busy(busy_b)
  );

  // Record every accepted word as {parity_err, frame_err, data} and count overrun pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && ready_a) qa.push_back({parity_err_a, frame_err_a, data_a});
      if (overrun_a) ovr_a++;
      if (busy_a) busy_seen = 1;
      if (valid_b && ready_b) qb.push_back({parity_err_b, frame_err_b, data_b});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx_a = b;
    else          rx_b = b;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    logic [10:0] v;
    int n;
    v = 11'h7FF;
    v[0] = 1'b0;
    for (int i = 0; i < 8; i++) v[i+1] = d[i];
    n = 9;
    if (use_par) begin
      v[n] = par;
      n++;
    end
    v[n] = stop;
    n++;
    for (int i = 0; i < n; i++) begin
      set_line(sel, v[i]);
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] get_a(input int i);
    if (i < qa.size()) return qa[i];
    return 10'h3FF;
  endfunction

  function automatic logic [9:0] get_b(input int i);
    if (i < qb.size()) return qb[i];
    return 10'h3FF;
  endfunction

  initial begin
    // Reset values
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_data", 32'(data_a), 32'd0);
    check_eq("rst_ferr", 32'(frame_err_a), 32'd0);
    check_eq("rst_perr", 32'(parity_err_a), 32'd0);
    check_eq("rst_ovr", 32'(overrun_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean frame 0xA5, consumer always ready
    qa.delete();
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_bits(2);
    check_eq("a5_count", 32'(qa.size()), 32'd1);
    check_eq("a5_word", 32'(get_a(0)), 32'h0A5);

    // Low stop bit then a clean 0x55
    qa.delete();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    set_line(0, 1'b1);
    wait_bits(1);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_bits(2);
    check_eq("ferr_count", 32'(qa.size()), 32'd2);
    check_eq("ferr_word", 32'(get_a(0)), 32'h13C);
    check_eq("after_ferr_word", 32'(get_a(1)), 32'h055);

    // Two-sample glitch on the idle line
    qa.delete();
    busy_seen = 0;
    set_line(0, 1'b0);
    repeat (26) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    for (int k = 0; k < BIT && busy_a; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("glitch_busy_clear", 32'(busy_a), 32'd0);
    check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
    wait_bits(2);
    check_eq("glitch_no_word", 32'(qa.size()), 32'd0);

    // Overrun: five frames into a four-entry FIFO with ready low
    qa.delete();
    ovr_a = 0;
    ready_a = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b0, 1'b1);
    wait_bits(1);
    @(negedge clk);
    check_eq("ovr_valid", 32'(valid_a), 32'd1);
    check_eq("ovr_head", 32'(data_a), 32'h01);
    check_eq("ovr_pulses", 32'(ovr_a), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("ovr_head_stable", 32'(data_a), 32'h01);
    check_eq("ovr_no_pop", 32'(qa.size()), 32'd0);
    @(posedge clk);
    #1 ready_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("drain_count", 32'(qa.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("drain_word", 32'(get_a(i)), 32'(i + 1));
    @(negedge clk);
    check_eq("drain_empty", 32'(valid_a), 32'd0);

    // Reset in data bit 3 of 0xFF, then 0x81
    qa.delete();
    set_line(0, 1'b0);
    repeat (BIT) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    repeat (3 * BIT + 50) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy_a), 32'd0);
    check_eq("midrst_valid", 32'(valid_a), 32'd0);
    repeat (5 * BIT - 52) @(posedge clk);
    #1;
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    wait_bits(2);
    check_eq("midrst_count", 32'(qa.size()), 32'd1);
    check_eq("midrst_word", 32'(get_a(0)), 32'h081);

    // Even parity instance: 0x07 has three ones
    qb.delete();
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_bits(2);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_bits(2);
    check_eq("par_count", 32'(qb.size()), 32'd2);
    check_eq("par_bad_word", 32'(get_b(0)), 32'h207);
    check_eq("par_good_word", 32'(get_b(1)), 32'h007);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
